// File: rtl/des_key_sched_ctrl_if.sv
// Key-schedule controller bus.
// master: key-input stage / round datapath side (drives start, decrypt, key_in, next).
// slave : des_key_sched_ctrl (drives mux_sel, round_key, round_idx, key_valid, busy, done).
interface des_key_sched_ctrl_if;
    localparam int unsigned KEY_W = 56;
    localparam int unsigned IDX_W = 4;

    logic             start;
    logic             decrypt;
    logic [KEY_W-1:0] key_in;
    logic             next;
    logic             mux_sel;
    logic [KEY_W-1:0] round_key;
    logic [IDX_W-1:0] round_idx;
    logic             key_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, decrypt, key_in, next,
        input  mux_sel, round_key, round_idx, key_valid, busy, done
    );

    modport slave (
        input  start, decrypt, key_in, next,
        output mux_sel, round_key, round_idx, key_valid, busy, done
    );
endinterface

// File: rtl/des_key_sched_ctrl.sv
// DES key-schedule controller: owns the post-PC-1 C/D register and steps it
// through 16 rounds (rotate left for encrypt, right for decrypt), presenting
// one pre-PC-2 round key per round and advancing when the datapath asserts next.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - slave side of des_key_sched_ctrl_if:
//          start/decrypt/key_in/next in; mux_sel (combinational), round_key,
//          round_idx, key_valid, busy, done out (registered).
module des_key_sched_ctrl #(
    parameter int unsigned KEY_W  = 56,
    parameter int unsigned ROUNDS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    des_key_sched_ctrl_if.slave  bus
);
    localparam int unsigned HALF_W = KEY_W / 2;
    localparam int unsigned IDX_W  = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [KEY_W-1:0]   cd_reg;
    logic [IDX_W-1:0]   idx_q;
    logic               dec_q;
    logic               key_valid_q;
    logic               busy_q;
    logic               done_q;

    logic               load;
    logic [IDX_W-1:0]   idx_nxt;
    logic [KEY_W-1:0]   mux_out;
    logic               rot_dec;
    logic [1:0]         rot_amt;
    logic [KEY_W-1:0]   cd_nxt;

    // Per-round shift amount; decrypt round 0 uses the key unshifted.
    function automatic logic [1:0] shift_amt(input logic [IDX_W-1:0] r, input logic dec);
        if (r == IDX_W'(0))
            return dec ? 2'd0 : 2'd1;
        if (r == IDX_W'(1) || r == IDX_W'(8) || r == IDX_W'(15))
            return 2'd1;
        return 2'd2;
    endfunction

    // Rotate one half by 0..2 positions; left for encrypt, right for decrypt.
    function automatic logic [HALF_W-1:0] rot_half(input logic [HALF_W-1:0] h,
                                                   input logic dec, input logic [1:0] amt);
        logic [HALF_W-1:0] r;
        r = h;
        case (amt)
            2'd1: r = dec ? {h[0], h[HALF_W-1:1]} : {h[HALF_W-2:0], h[HALF_W-1]};
            2'd2: r = dec ? {h[1:0], h[HALF_W-1:2]} : {h[HALF_W-3:0], h[HALF_W-1:HALF_W-2]};
            default: r = h;
        endcase
        return r;
    endfunction

    // Load/feedback mux select: key_in only on an accepted start.
    assign load        = (state == IDLE) && bus.start;
    assign bus.mux_sel = load;

    // 2:1 load/feedback mux followed by the independent C/D rotation.
    always_comb begin
        idx_nxt = IDX_W'(idx_q + IDX_W'(1));
        mux_out = cd_reg;
        rot_dec = dec_q;
        rot_amt = shift_amt(idx_nxt, dec_q);
        if (load) begin
            mux_out = bus.key_in;
            rot_dec = bus.decrypt;
            rot_amt = shift_amt(IDX_W'(0), bus.decrypt);
        end
        cd_nxt = {rot_half(mux_out[KEY_W-1:HALF_W], rot_dec, rot_amt),
                  rot_half(mux_out[HALF_W-1:0],     rot_dec, rot_amt)};
    end

    // Schedule FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cd_reg      <= '0;
            idx_q       <= '0;
            dec_q       <= 1'b0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (load) begin
                        cd_reg      <= cd_nxt;
                        dec_q       <= bus.decrypt;
                        idx_q       <= '0;
                        key_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (bus.next) begin
                        if (idx_q == LAST_IDX) begin
                            key_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            state       <= DONE;
                        end else begin
                            idx_q  <= idx_nxt;
                            cd_reg <= cd_nxt;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    key_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.round_key = cd_reg;
    assign bus.round_idx = idx_q;
    assign bus.key_valid = key_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
